fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-cycle instruction fetch with stall, redirect and halt/resume handling
module fetch_unit #(
  parameter int                 ADDR_W     = 4,
  parameter int                 INSTR_W    = 16,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               resume,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] ir_n;
  logic [ADDR_W-1:0]  ir_pc_n;
  logic               ir_valid_n;

  assign imem_addr = pc;
  assign halted    = state == HALT;

  // Next-state logic: redirect overrides everything, otherwise per-state fetch/hold/halt behaviour
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    if (redirect) begin
      state_n    = RUN;
      pc_n       = redirect_addr;
      ir_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n    = RUN;
          ir_valid_n = 1'b0;
        end
        RUN: begin
          if (!stall) begin
            ir_n       = imem_data;
            ir_pc_n    = pc;
            ir_valid_n = 1'b1;
            if (imem_data == HALT_INSTR) state_n = HALT;
            else pc_n = pc + 1'b1;
          end
        end
        HALT: begin
          ir_valid_n = 1'b0;
          if (resume) begin
            state_n = RUN;
            pc_n    = pc + 1'b1;
          end
        end
        default: begin
          state_n    = IDLE;
          ir_valid_n = 1'b0;
        end
      endcase
    end
  end

  // State and fetch registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [3:0]  redirect_addr = '0;
  logic        resume = 1'b0;
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        halted;

  logic [15:0] mem [16];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [3:0]  raddr;
    logic        resume;
    logic [3:0]  e_addr;
    logic [15:0] e_ir;
    logic [3:0]  e_irpc;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs [27];
  vec_t sb [$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr), .resume(resume),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  function automatic vec_t mk(input logic s, input logic r, input logic [3:0] ra, input logic rs,
                              input logic [3:0] a, input logic [15:0] i, input logic [3:0] ip,
                              input logic v, input logic h);
    vec_t t;
    t.stall = s; t.redirect = r; t.raddr = ra; t.resume = rs;
    t.e_addr = a; t.e_ir = i; t.e_irpc = ip; t.e_valid = v; t.e_halted = h;
    return t;
  endfunction

  task automatic check(input string name, input vec_t e);
    tests++;
    if (imem_addr !== e.e_addr || ir !== e.e_ir || ir_pc !== e.e_irpc ||
        ir_valid !== e.e_valid || halted !== e.e_halted) begin
      fails++;
      $display("FAIL %s: got addr=%h ir=%h ir_pc=%h valid=%b halted=%b, want addr=%h ir=%h ir_pc=%h valid=%b halted=%b",
               name, imem_addr, ir, ir_pc, ir_valid, halted,
               e.e_addr, e.e_ir, e.e_irpc, e.e_valid, e.e_halted);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    vec_t e;
    stall = v.stall; redirect = v.redirect; redirect_addr = v.raddr; resume = v.resume;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, e);
  endtask

  task automatic check_zero(input string name);
    check(name, mk(0, 0, 0, 0, 4'h0, 16'h0000, 4'h0, 0, 0));
  endtask

  initial begin
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'hFFFF; mem[6] = 16'h6666; mem[7] = 16'h7777;
    mem[8] = 16'h8888; mem[9] = 16'h9999; mem[10] = 16'hA0A0; mem[11] = 16'hB0B0;
    mem[12] = 16'hC0C0; mem[13] = 16'hD0D0; mem[14] = 16'hE0E0; mem[15] = 16'hABCD;

    //            stall red raddr res | addr  ir        irpc  v  h
    vecs[0]  = mk(0, 0, 4'd0,  0, 4'd0,  16'h0000, 4'd0,  0, 0);
    vecs[1]  = mk(0, 0, 4'd0,  0, 4'd1,  16'h1111, 4'd0,  1, 0);
    vecs[2]  = mk(0, 0, 4'd0,  0, 4'd2,  16'h2222, 4'd1,  1, 0);
    vecs[3]  = mk(1, 0, 4'd0,  0, 4'd2,  16'h2222, 4'd1,  1, 0);
    vecs[4]  = mk(1, 0, 4'd0,  0, 4'd2,  16'h2222, 4'd1,  1, 0);
    vecs[5]  = mk(1, 0, 4'd0,  0, 4'd2,  16'h2222, 4'd1,  1, 0);
    vecs[6]  = mk(0, 0, 4'd0,  0, 4'd3,  16'h3333, 4'd2,  1, 0);
    vecs[7]  = mk(0, 0, 4'd0,  0, 4'd4,  16'h4444, 4'd3,  1, 0);
    vecs[8]  = mk(1, 1, 4'd9,  0, 4'd9,  16'h4444, 4'd3,  0, 0);
    vecs[9]  = mk(0, 0, 4'd0,  0, 4'd10, 16'h9999, 4'd9,  1, 0);
    vecs[10] = mk(0, 1, 4'd4,  0, 4'd4,  16'h9999, 4'd9,  0, 0);
    vecs[11] = mk(0, 0, 4'd0,  0, 4'd5,  16'h5555, 4'd4,  1, 0);
    vecs[12] = mk(0, 0, 4'd0,  0, 4'd5,  16'hFFFF, 4'd5,  1, 1);
    vecs[13] = mk(1, 0, 4'd0,  0, 4'd5,  16'hFFFF, 4'd5,  0, 1);
    vecs[14] = mk(0, 0, 4'd0,  0, 4'd5,  16'hFFFF, 4'd5,  0, 1);
    vecs[15] = mk(0, 0, 4'd0,  1, 4'd6,  16'hFFFF, 4'd5,  0, 0);
    vecs[16] = mk(0, 0, 4'd0,  0, 4'd7,  16'h6666, 4'd6,  1, 0);
    vecs[17] = mk(1, 0, 4'd0,  1, 4'd7,  16'h6666, 4'd6,  1, 0);
    vecs[18] = mk(0, 0, 4'd0,  1, 4'd8,  16'h7777, 4'd7,  1, 0);
    vecs[19] = mk(0, 1, 4'd15, 0, 4'd15, 16'h7777, 4'd7,  0, 0);
    vecs[20] = mk(0, 0, 4'd0,  0, 4'd0,  16'hABCD, 4'd15, 1, 0);
    vecs[21] = mk(0, 0, 4'd0,  0, 4'd1,  16'h1111, 4'd0,  1, 0);
    vecs[22] = mk(0, 1, 4'd5,  0, 4'd5,  16'h1111, 4'd0,  0, 0);
    vecs[23] = mk(1, 0, 4'd0,  0, 4'd5,  16'h1111, 4'd0,  0, 0);
    vecs[24] = mk(0, 0, 4'd0,  0, 4'd5,  16'hFFFF, 4'd5,  1, 1);
    vecs[25] = mk(1, 1, 4'd2,  1, 4'd2,  16'hFFFF, 4'd5,  0, 0);
    vecs[26] = mk(0, 0, 4'd0,  0, 4'd3,  16'h3333, 4'd2,  1, 0);

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) step($sformatf("vec%0d", i), vecs[i]);

    step("to_pc7", mk(0, 1, 4'd7, 0, 4'd7, 16'h3333, 4'd2, 0, 0));
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_run");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_run_reset", mk(0, 0, 0, 0, 4'd0, 16'h0000, 4'd0, 0, 0));
    step("refetch_0", mk(0, 0, 0, 0, 4'd1, 16'h1111, 4'd0, 1, 0));

    step("redir_5", mk(0, 1, 4'd5, 0, 4'd5, 16'h1111, 4'd0, 0, 0));
    step("halt_again", mk(0, 0, 0, 0, 4'd5, 16'hFFFF, 4'd5, 1, 1));
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_halt");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_halt_reset", mk(0, 0, 0, 1, 4'd0, 16'h0000, 4'd0, 0, 0));
    step("refetch_after_halt", mk(0, 0, 0, 1, 4'd1, 16'h1111, 4'd0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
